// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the HI/LO multiply/divide unit.
//   MULDIV_DW : default operand / HI / LO width
//   op_e      : request opcode encodings carried on muldiv.op
//   state_e   : sequencing states of the muldiv control FSM
package muldiv_pkg;

  localparam int unsigned MULDIV_DW = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// div_core -- iterative radix-2 restoring divider, one quotient bit per cycle,
// MSB first, operating on magnitudes with a final sign fix-up.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : load operands (one-cycle strobe)
//   is_signed   : 1 = DIV semantics, 0 = DIVU semantics
//   dividend    : A operand, divisor : B operand
//   ready       : high once all DATA_WIDTH iterations are complete
//   quotient    : sign-corrected quotient (all ones on divide-by-zero)
//   remainder   : sign-corrected remainder (dividend on divide-by-zero)
module div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DW
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                  neg_a, neg_b;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [DATA_WIDTH:0]   trial;

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, raw_a_q;
  logic [CW-1:0]         cnt_q;
  logic                  run_q, rdy_q, q_neg_q, r_neg_q, dz_q;

  assign neg_a = is_signed & dividend[DATA_WIDTH-1];
  assign neg_b = is_signed & divisor[DATA_WIDTH-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;

  // quo_q starts as the dividend magnitude; its MSB is shifted into the
  // partial remainder while quotient bits enter at the LSB.
  assign trial = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_a_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      rdy_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (start) begin
      rem_q   <= '0;
      quo_q   <= mag_a;
      dvs_q   <= mag_b;
      raw_a_q <= dividend;
      cnt_q   <= '0;
      run_q   <= 1'b1;
      rdy_q   <= 1'b0;
      q_neg_q <= neg_a ^ neg_b;
      r_neg_q <= neg_a;
      dz_q    <= (divisor == '0);
    end else if (run_q) begin
      if (!trial[DATA_WIDTH]) begin
        rem_q <= trial[DATA_WIDTH-1:0];
        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        run_q <= 1'b0;
        rdy_q <= 1'b1;
      end
    end
  end

  // Divide-by-zero bypasses the sign fix-up so signed and unsigned agree.
  // Most-negative / -1 needs no special case: negating the 2^(W-1)
  // magnitude wraps back to the most-negative value.
  assign ready     = rdy_q;
  assign quotient  = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
  assign remainder = dz_q ? raw_a_q : (r_neg_q ? -rem_q : rem_q);

endmodule

// File: rtl/muldiv.sv
// muldiv -- multi-cycle multiply/divide unit with architectural HI/LO.
//   clk, resetn : clock, asynchronous active-low reset
//   op_valid/op : request strobe and opcode (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   A, B        : operands, captured at acceptance
//   busy        : MUL/DIV in flight (MUL, DIV, FIN states)
//   done        : one-cycle pulse while in FIN, HI/LO just updated
//   hi, lo      : HI/LO registers
// Build option: define MULDIV_DIV_EN to include the iterative divider
// (div_core); otherwise DIV/DIVU complete in one cycle leaving HI/LO intact.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DW
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  state_e state_q, state_d;

  logic acc_mul, acc_div, acc_mthi, acc_mtlo;

  logic                    mul_signed_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [2*DATA_WIDTH-1:0] a_ext, b_ext, product;

  always_comb begin
    acc_mul  = 1'b0;
    acc_div  = 1'b0;
    acc_mthi = 1'b0;
    acc_mtlo = 1'b0;
    if (op_valid && state_q == S_IDLE) begin
      case (op)
        OP_MULT, OP_MULTU: acc_mul  = 1'b1;
        OP_DIV,  OP_DIVU:  acc_div  = 1'b1;
        OP_MTHI:           acc_mthi = 1'b1;
        OP_MTLO:           acc_mtlo = 1'b1;
        default: ;
      endcase
    end
  end

  // Extending to 2W before multiplying makes the truncated 2W product equal
  // the exact signed (or unsigned) full-width product.
  assign a_ext   = {{DATA_WIDTH{mul_signed_q & a_q[DATA_WIDTH-1]}}, a_q};
  assign b_ext   = {{DATA_WIDTH{mul_signed_q & b_q[DATA_WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

`ifdef MULDIV_DIV_EN
  logic                  div_rdy;
  logic [DATA_WIDTH-1:0] div_quo, div_rem;

  div_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .start     (acc_div),
    .is_signed (op == OP_DIV),
    .dividend  (A),
    .divisor   (B),
    .ready     (div_rdy),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    case (state_q)
      S_IDLE: begin
        if (acc_mul) begin
          state_d = S_MUL;
        end else if (acc_div) begin
`ifdef MULDIV_DIV_EN
          state_d = S_DIV;
`else
          state_d = S_FIN;
`endif
        end
      end
      S_MUL: state_d = S_FIN;
      S_DIV: begin
`ifdef MULDIV_DIV_EN
        if (div_rdy) state_d = S_FIN;
`else
        state_d = S_IDLE;
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      mul_signed_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      state_q <= state_d;
      if (acc_mul) begin
        mul_signed_q <= (op == OP_MULT);
        a_q          <= A;
        b_q          <= B;
      end
      if (acc_mthi) hi <= A;
      if (acc_mtlo) lo <= A;
      if (state_q == S_MUL) begin
        hi <= product[2*DATA_WIDTH-1:DATA_WIDTH];
        lo <= product[DATA_WIDTH-1:0];
      end
`ifdef MULDIV_DIV_EN
      if (state_q == S_DIV && div_rdy) begin
        hi <= div_rem;
        lo <= div_quo;
      end
`endif
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv -- scoreboard bench for muldiv: expected HI/LO/latency are pushed
// when a MUL/DIV request is issued and popped when done is observed.
module tb_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam int DIV_LAT = 34;
  localparam int RST_AT  = 10;
`else
  localparam int DIV_LAT = 1;
  localparam int RST_AT  = 0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv #(
    .DATA_WIDTH(W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_expect(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      la, lb;
    logic [63:0] p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    e.hi = m_hi;
    e.lo = m_lo;
    e.lat = 2;
    case (o)
      OP_MULT: begin
        p = la * lb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        e.lat = DIV_LAT;
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else if (o == OP_DIV) begin
          e.lo = 32'(la / lb);
          e.hi = 32'(la % lb);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
`endif
      end
    endcase
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int   lat;
    lat = 0;
    e = sb.pop_front();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_cmp++;
    if (lat != e.lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (0 = timeout) expected %0d", name, lat, e.lat);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
    end
    n_cmp++;
    if (hi !== e.hi) begin
      n_bad++;
      $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
    end
    n_cmp++;
    if (lo !== e.lo) begin
      n_bad++;
      $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    push_expect(o, a, b);
    issue(o, a, b);
    wait_result(name);
  endtask

  task automatic check_idle(input string name, input logic [31:0] eh, input logic [31:0] el);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b expected 0", name, busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL %s done: got %b expected 0", name, done); end
    n_cmp++;
    if (hi !== eh) begin n_bad++; $display("FAIL %s hi: got %h expected %h", name, hi, eh); end
    n_cmp++;
    if (lo !== el) begin n_bad++; $display("FAIL %s lo: got %h expected %h", name, lo, el); end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    op_valid = 1'b0;
    op = 3'b000;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_held", 32'd0, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_idle("reset_released", 32'd0, 32'd0);
  endtask

  task automatic test_mult;
    logic [31:0] a, b;
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_m1x2");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_ffx2");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_maxxmax");
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(OP_MULT, a, b, "mult_rand");
      run_op(OP_MULTU, a, b, "multu_rand");
    end
  endtask

  task automatic test_div;
    logic [31:0] a, b;
    run_op(OP_DIVU, 32'd100,       32'd7,         "divu_100_7");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         "div_m7_2");
    run_op(OP_DIVU, 32'd5,         32'd0,         "divu_by_zero");
    run_op(OP_DIV,  32'hFFFF_FFF0, 32'd0,         "div_neg_by_zero");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, "div_7_m2");
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(OP_DIV, a, b, "div_rand");
      run_op(OP_DIVU, a, b, "divu_rand");
    end
  endtask

  task automatic test_mt;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    m_hi = 32'h1234_5678;
    check_idle("mthi", m_hi, m_lo);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    m_lo = 32'h9ABC_DEF0;
    check_idle("mtlo", m_hi, m_lo);
    @(negedge clk);
    check_idle("mt_after", m_hi, m_lo);
    issue(3'b110, 32'hAAAA_AAAA, 32'h5555_5555);
    @(negedge clk);
    check_idle("op110", m_hi, m_lo);
    issue(3'b111, 32'hAAAA_AAAA, 32'h5555_5555);
    @(negedge clk);
    check_idle("op111", m_hi, m_lo);
  endtask

  task automatic test_mthi_during_div;
    push_expect(OP_DIVU, 32'd1000, 32'd9);
    issue(OP_DIVU, 32'd1000, 32'd9);
    fork
      wait_result("div_with_mthi");
      begin
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_MTHI;
        A = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
      end
    join
    @(negedge clk);
    check_idle("mthi_dropped", m_hi, m_lo);
  endtask

  task automatic test_busy_drop;
    int dones;
    push_expect(OP_MULT, 32'hFFFF_FFFD, 32'd11);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd11);
    fork
      wait_result("mult_then_drop");
      begin
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_MULTU;
        A = 32'h0001_0000;
        B = 32'h0001_0000;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
      end
    join
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done);
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL busy_drop extra_done: got %0d pulses expected 0", dones);
    end
    check_idle("busy_drop_state", m_hi, m_lo);

    // Request raised in the FIN cycle and held: taken once state is IDLE.
    push_expect(OP_MULT, 32'd3, 32'd5);
    issue(OP_MULT, 32'd3, 32'd5);
    wait_result("b2b_first");
    push_expect(OP_MULTU, 32'hFFFF_0000, 32'h0001_0001);
    op_valid = 1'b1;
    op = OP_MULTU;
    A = 32'hFFFF_0000;
    B = 32'h0001_0001;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: got busy=%b done=%b expected 0/0", busy, done);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wait_result("b2b_second");
  endtask

  task automatic test_reset_mid;
    int dones;
    push_expect(OP_DIV, 32'hFFFF_CFC7, 32'd7);
    void'(sb.pop_back());
    issue(OP_DIV, 32'hFFFF_CFC7, 32'd7);
    dones = 0;
    repeat (RST_AT) begin
      @(negedge clk);
      dones += int'(done);
    end
    resetn = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check_idle("reset_mid", 32'd0, 32'd0);
    repeat (2) begin
      @(negedge clk);
      dones += int'(done);
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dones += int'(done);
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL reset_mid done_pulses: got %0d expected 0", dones);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, "divu_after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_mthi_during_div();
    test_busy_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  input  1  request strobe, sampled on clk rising edge.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-006 SHALL have port A  input  DATA_WIDTH  multiplicand / dividend / MTHI/MTLO source.
REQ-007 SHALL have port B  input  DATA_WIDTH  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  high while a MULT/DIV is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse, HI/LO updated by the completing op.
REQ-010 SHALL have ports hi, lo  output  DATA_WIDTH each  architectural HI/LO registers.

Function
REQ-011 SHALL accept a request on an edge where op_valid=1 and busy=0; requests while busy=1 SHALL be dropped without effect.
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV, FIN: IDLE->MUL on MULT/MULTU accept, IDLE->DIV on DIV/DIVU accept, MUL->FIN after 1 cycle, DIV->FIN after 32 iteration cycles, FIN->IDLE after 1 cycle.
REQ-013 SHALL latch A, B and op at acceptance; later changes on inputs SHALL NOT affect the result.
REQ-014 SHALL write {hi,lo} = full 2*DATA_WIDTH product (signed for MULT, unsigned for MULTU) on the edge entering FIN; done=1 during FIN, i.e. 2 cycles after acceptance.
REQ-015 SHALL compute DIV/DIVU with radix-2 restoring iteration, 1 quotient bit per cycle, MSB first; lo=quotient, hi=remainder, written on the edge entering FIN; done=1 34 cycles after acceptance.
REQ-016 DIV SHALL divide magnitudes and correct signs: quotient truncates toward zero, remainder takes the sign of the dividend.
REQ-017 Divisor zero SHALL give lo=all ones, hi=dividend A (both DIV and DIVU), same latency.
REQ-018 DIV of most-negative by -1 SHALL give lo=most-negative value, hi=0.
REQ-019 busy SHALL be 1 in MUL, DIV and FIN, 0 in IDLE; a new request is accepted no earlier than the edge leaving FIN.
REQ-020 MTHI/MTLO SHALL write A to hi/lo at the acceptance edge, with no busy and no done, and only when busy=0.
REQ-021 Ops 110/111 SHALL be ignored completely.

Reset
REQ-022 resetn=0 SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0 and clear iteration counter/datapath registers.
REQ-023 Reset during MUL/DIV/FIN SHALL abort the op with no done pulse; the first post-reset request SHALL behave as if issued from power-up.

Configuration
REQ-024 With macro MULDIV_DIV_EN defined, division SHALL be implemented per REQ-015..018.
REQ-025 Without MULDIV_DIV_EN, DIV/DIVU SHALL be accepted, go IDLE->FIN directly, pulse done 1 cycle after acceptance, and leave hi/lo unchanged; no divider logic SHALL be synthesized.

Structure
REQ-026 SHALL put op encodings, FSM state encodings and DATA_WIDTH default in shared package muldiv_pkg.
REQ-027 SHALL place the iterative divider datapath (remainder/quotient shift registers, 5-bit counter, sign fix-up) in sub-module div_core, instantiated only under MULDIV_DIV_EN.

Verification
REQ-028 MULT A=0xFFFFFFFF B=0x00000002 -> done 2 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-029 DIVU A=100 B=7 -> busy for 34 cycles, done at cycle 34, lo=14, hi=2; DIV A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 DIVU A=5 B=0 -> lo=0xFFFFFFFF, hi=5; DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 Issue MULT then MULTU while busy -> only the first executes, exactly one done pulse; back-to-back op at the FIN->IDLE edge is accepted.
REQ-032 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 in idle -> hi/lo updated next edge, busy and done stay 0; MTHI during DIV -> dropped.
REQ-033 Assert resetn=0 10 cycles into a DIV -> busy=0, hi=lo=0 immediately, no done; a following DIVU 9/3 -> lo=3, hi=0 at normal latency.
